// File: rtl/mem_wb_pkg.sv
// Shared encodings for the MEM/WB stage: write-back source, load size and FSM state.
package mem_wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic {
        CAPTURE  = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Sized-load lane extraction with sign/zero extension; lane logic assumes a 32-bit word.
module load_extend
    import mem_wb_pkg::*;
#(
    parameter int d_size = 32
) (
    input  logic [d_size-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic [d_size-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        // Half-word lane follows addr_lo[1] only; a misaligned bit 0 is ignored.
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            LD_BYTE: data = {{24{~ld_unsigned & byte_v[7]}}, byte_v};
            LD_HALF: data = {{16{~ld_unsigned & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects write-back data, extends loads, waits for slow memory,
// and commits each instruction to the register file exactly once.
//   state    | meaning
//   CAPTURE  | normal; held data resolved, new instruction may be captured
//   WAIT_MEM | held load waiting for mem_rsp_valid; upstream held via stall_req
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int d_size    = 32,
    parameter int ad_size   = 32,
    parameter int ra_size   = 5,
    parameter int REG0_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_regwrite,
    input  logic [1:0]         ex_wb_sel,
    input  logic [1:0]         ex_ld_size,
    input  logic               ex_ld_unsigned,
    input  logic [1:0]         ex_addr_lo,
    input  logic [ra_size-1:0] ex_rd,
    input  logic [d_size-1:0]  ex_result,
    input  logic [ad_size-1:0] ex_pc4,
    input  logic               mem_rsp_valid,
    input  logic [d_size-1:0]  mem_rdata,
    input  logic               stall_in,
    input  logic               flush,
    output logic               stall_req,
    output logic               wb_we,
    output logic [ra_size-1:0] wb_rd,
    output logic [d_size-1:0]  wb_data,
    output logic [d_size-1:0]  DATA
);

    wb_state_e          state_q;
    logic               valid_q;
    logic               regwrite_q;
    logic               committed_q;
    logic [ra_size-1:0] rd_q;
    logic [d_size-1:0]  data_q;
    logic [d_size-1:0]  data_out_q;
    logic [1:0]         ld_size_q;
    logic [1:0]         addr_lo_q;
    logic               ld_unsigned_q;

    logic [1:0]         ext_size;
    logic [1:0]         ext_addr;
    logic               ext_unsigned;
    logic [d_size-1:0]  ext_data;
    logic [d_size-1:0]  sel_data;
    logic               rd_is_zero;
    logic               capture_load_wait;

    // While waiting, the extender works on the held load fields instead of the incoming ones.
    always_comb begin
        if (state_q == WAIT_MEM) begin
            ext_size     = ld_size_q;
            ext_addr     = addr_lo_q;
            ext_unsigned = ld_unsigned_q;
        end else begin
            ext_size     = ex_ld_size;
            ext_addr     = ex_addr_lo;
            ext_unsigned = ex_ld_unsigned;
        end
    end

    load_extend #(
        .d_size(d_size)
    ) u_load_extend (
        .rdata      (mem_rdata),
        .addr_lo    (ext_addr),
        .size       (ext_size),
        .ld_unsigned(ext_unsigned),
        .data       (ext_data)
    );

    always_comb begin
        case (ex_wb_sel)
            WB_SEL_MEM: sel_data = ext_data;
            WB_SEL_PC4: sel_data = d_size'(ex_pc4);
            default:    sel_data = ex_result;
        endcase
    end

    assign rd_is_zero        = (rd_q == '0);
    assign capture_load_wait = ex_valid && (ex_wb_sel == WB_SEL_MEM) && !mem_rsp_valid;

    assign stall_req = (state_q == WAIT_MEM);
    assign wb_we     = valid_q && regwrite_q && (state_q == CAPTURE) && !committed_q
                       && !((REG0_ZERO != 0) && rd_is_zero);
    assign wb_rd     = rd_q;
    assign wb_data   = data_q;
    assign DATA      = data_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= CAPTURE;
            valid_q       <= 1'b0;
            regwrite_q    <= 1'b0;
            committed_q   <= 1'b0;
            rd_q          <= '0;
            data_q        <= '0;
            data_out_q    <= '0;
            ld_size_q     <= LD_BYTE;
            addr_lo_q     <= 2'd0;
            ld_unsigned_q <= 1'b0;
        end else begin
            // A write presented this cycle always lands, even if flush or capture follows.
            if (wb_we) begin
                committed_q <= 1'b1;
                data_out_q  <= data_q;
            end

            if (flush) begin
                valid_q     <= 1'b0;
                state_q     <= CAPTURE;
                committed_q <= 1'b0;
            end else if (state_q == WAIT_MEM) begin
                if (mem_rsp_valid) begin
                    data_q  <= ext_data;
                    state_q <= CAPTURE;
                end
            end else if (!stall_in) begin
                valid_q       <= ex_valid;
                regwrite_q    <= ex_regwrite;
                rd_q          <= ex_rd;
                ld_size_q     <= ex_ld_size;
                addr_lo_q     <= ex_addr_lo;
                ld_unsigned_q <= ex_ld_unsigned;
                data_q        <= sel_data;
                committed_q   <= 1'b0;
                if (capture_load_wait) begin
                    state_q <= WAIT_MEM;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a rule-level reference model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_regwrite;
    logic [1:0]  ex_wb_sel;
    logic [1:0]  ex_ld_size;
    logic        ex_ld_unsigned;
    logic [1:0]  ex_addr_lo;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [31:0] ex_pc4;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        stall_in;
    logic        flush;
    logic        stall_req;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] DATA;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one instruction slot, described by what it is and whether it is done.
    bit          m_valid;
    bit          m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_waiting;
    bit          m_done;
    logic [31:0] m_last;
    logic [1:0]  m_size;
    logic [1:0]  m_addr;
    bit          m_uns;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_regwrite   (ex_regwrite),
        .ex_wb_sel     (ex_wb_sel),
        .ex_ld_size    (ex_ld_size),
        .ex_ld_unsigned(ex_ld_unsigned),
        .ex_addr_lo    (ex_addr_lo),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_pc4        (ex_pc4),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .stall_in      (stall_in),
        .flush         (flush),
        .stall_req     (stall_req),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .DATA          (DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] addr,
                                             input logic [1:0] size, input bit uns);
        logic [31:0] v;
        int          w;
        if (size == 2'd0) begin
            v = (word >> (8 * addr)) & 32'hFF;
            w = 8;
        end else if (size == 2'd1) begin
            v = (word >> (16 * (addr / 2))) & 32'hFFFF;
            w = 16;
        end else begin
            return word;
        end
        if (!uns && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
        return v;
    endfunction

    function automatic bit ref_we();
        return m_valid && m_rw && !m_waiting && !m_done && (m_rd != 5'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0;
        m_waiting = 0; m_done = 0; m_last = 0;
        m_size = 0; m_addr = 0; m_uns = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        if (ref_we()) begin
            m_last = m_data;
            m_done = 1;
        end
        if (flush) begin
            m_valid = 0;
            m_waiting = 0;
            m_done = 0;
        end else if (m_waiting) begin
            if (mem_rsp_valid) begin
                m_data = ref_load(mem_rdata, m_addr, m_size, m_uns);
                m_waiting = 0;
            end
        end else if (!stall_in) begin
            m_valid = ex_valid; m_rw = ex_regwrite; m_rd = ex_rd; m_done = 0;
            m_size = ex_ld_size; m_addr = ex_addr_lo; m_uns = ex_ld_unsigned;
            if (ex_wb_sel == 2'b01) begin
                m_data = ref_load(mem_rdata, ex_addr_lo, ex_ld_size, ex_ld_unsigned);
                m_waiting = ex_valid && !mem_rsp_valid;
            end else if (ex_wb_sel == 2'b10) m_data = ex_pc4;
            else m_data = ex_result;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, ref_we()});
        chk({tag, ".stall_req"}, {31'd0, stall_req}, {31'd0, m_waiting});
        chk({tag, ".DATA"}, DATA, m_last);
        if (ref_we()) begin
            chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, m_rd});
            chk({tag, ".data"}, wb_data, m_data);
        end
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_op(input bit v, input bit rw, input logic [1:0] sel, input logic [1:0] size,
                          input bit uns, input logic [1:0] addr, input logic [4:0] rd,
                          input logic [31:0] res);
        ex_valid = v; ex_regwrite = rw; ex_wb_sel = sel; ex_ld_size = size;
        ex_ld_unsigned = uns; ex_addr_lo = addr; ex_rd = rd; ex_result = res;
    endtask

    task automatic idle();
        set_op(0, 0, 2'b00, 2'b10, 0, 2'd0, 5'd0, 32'd0);
        mem_rsp_valid = 0; stall_in = 0; flush = 0;
    endtask

    initial begin
        rst = 1'b0;
        ex_pc4 = 32'h0000_1004;
        mem_rdata = 32'd0;
        idle();
        model_reset();
        #2;
        chk("reset.we", {31'd0, wb_we}, 32'd0);
        chk("reset.stall_req", {31'd0, stall_req}, 32'd0);
        chk("reset.rd", {27'd0, wb_rd}, 32'd0);
        chk("reset.data", wb_data, 32'd0);
        chk("reset.DATA", DATA, 32'd0);
        #10 rst = 1'b1;

        // ALU op commits one cycle after capture, DATA follows one edge later.
        set_op(1, 1, 2'b00, 2'b10, 0, 2'd0, 5'd5, 32'h1234);
        cyc("alu");
        chk("alu.we_const", {31'd0, wb_we}, 32'd1);
        chk("alu.rd_const", {27'd0, wb_rd}, 32'd5);
        chk("alu.data_const", wb_data, 32'h1234);
        idle();
        cyc("alu_after");
        chk("alu.DATA_const", DATA, 32'h1234);

        // Signed byte and unsigned half loads with same-cycle response.
        set_op(1, 1, 2'b01, 2'b00, 0, 2'd3, 5'd6, 32'd0);
        mem_rsp_valid = 1; mem_rdata = 32'h80FF7F01;
        cyc("lb");
        chk("lb.data_const", wb_data, 32'hFFFFFF80);
        set_op(1, 1, 2'b01, 2'b01, 1, 2'd2, 5'd7, 32'd0);
        cyc("lhu");
        chk("lhu.data_const", wb_data, 32'h000080FF);
        idle();
        cyc("lhu_after");

        // Delayed response: three wait cycles, then a word.
        set_op(1, 1, 2'b01, 2'b10, 0, 2'd0, 5'd7, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc("wait");
            chk("wait.stall_const", {31'd0, stall_req}, 32'd1);
        end
        mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
        cyc("wait_rsp");
        chk("wait_rsp.we_const", {31'd0, wb_we}, 32'd1);
        chk("wait_rsp.data_const", wb_data, 32'hDEADBEEF);
        chk("wait_rsp.stall_const", {31'd0, stall_req}, 32'd0);
        idle();

        // Stall after commit: no repeated write.
        set_op(1, 1, 2'b00, 2'b10, 0, 2'd0, 5'd9, 32'hA5A5);
        cyc("stall_op");
        idle();
        stall_in = 1;
        for (int i = 0; i < 4; i++) begin
            cyc("stall_hold");
            chk("stall_hold.DATA_const", DATA, 32'hA5A5);
        end
        stall_in = 0;

        // Flush in WAIT_MEM with a simultaneous response.
        set_op(1, 1, 2'b01, 2'b10, 0, 2'd0, 5'd10, 32'd0);
        cyc("flush_wait");
        idle();
        flush = 1; mem_rsp_valid = 1; mem_rdata = 32'h11111111;
        cyc("flush");
        chk("flush.stall_const", {31'd0, stall_req}, 32'd0);
        flush = 0; mem_rsp_valid = 0;
        cyc("flush_after");
        chk("flush.DATA_const", DATA, 32'hA5A5);

        // Register 0 is never written.
        set_op(1, 1, 2'b00, 2'b10, 0, 2'd0, 5'd0, 32'h5555);
        cyc("rd0");
        chk("rd0.we_const", {31'd0, wb_we}, 32'd0);
        idle();
        cyc("rd0_after");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ex_valid       = ($urandom_range(7) != 0);
            ex_regwrite    = ($urandom_range(5) != 0);
            ex_wb_sel      = 2'($urandom_range(3));
            ex_ld_size     = 2'($urandom_range(3));
            ex_ld_unsigned = 1'($urandom_range(1));
            ex_addr_lo     = 2'($urandom_range(3));
            ex_rd          = 5'($urandom_range(31));
            ex_result      = $urandom;
            ex_pc4         = $urandom;
            mem_rdata      = $urandom;
            mem_rsp_valid  = ($urandom_range(1) == 1);
            stall_in       = ($urandom_range(7) == 0);
            flush          = ($urandom_range(15) == 0);
            cyc("rand");
        end
        idle();

        // Asynchronous reset in the middle of a wait.
        set_op(1, 1, 2'b01, 2'b10, 0, 2'd0, 5'd12, 32'd0);
        cyc("rst_wait");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst.we", {31'd0, wb_we}, 32'd0);
        chk("arst.stall_req", {31'd0, stall_req}, 32'd0);
        chk("arst.rd", {27'd0, wb_rd}, 32'd0);
        chk("arst.data", wb_data, 32'd0);
        chk("arst.DATA", DATA, 32'd0);
        idle();
        #2 rst = 1'b1;
        set_op(1, 1, 2'b10, 2'b10, 0, 2'd0, 5'd3, 32'd0);
        ex_pc4 = 32'h0000_2008;
        cyc("post_rst");
        chk("post_rst.data_const", wb_data, 32'h0000_2008);
        idle();
        cyc("post_rst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
